vram_arbiter: RTL and testbench

//   Shares the single-port VRAM between two requesters: display scan-out reads and CPU writes.

---
 rtl/vram_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares a single-port VRAM between display scan-out reads
// (default winner) and CPU writes queued in a small FIFO. Writes get a slot
// after at most MAX_BURST reads granted while the queue is non-empty.
//
// Handshakes:
//   display : i_disp_req is held with a stable i_disp_addr until o_disp_ack;
//             o_disp_ack is a one-cycle pulse with o_disp_data valid. A request
//             still high in the ack cycle is treated as the one being acked.
//   cpu     : a word is accepted on any edge where i_cpu_wr && o_cpu_ready.
//   vram    : o_vram_rden/o_vram_raddr held READ_HOLD cycles, data sampled on
//             the last edge; o_vram_wren is a single-cycle pulse answered by an
//             i_vram_wrack pulse (or abandoned after WR_TIMEOUT cycles).
module vram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int READ_HOLD  = 3,
    parameter int MAX_BURST  = 8,
    parameter int WR_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_disp_req,
    input  logic [13:0] i_disp_addr,
    output logic        o_disp_ack,
    output logic [15:0] o_disp_data,
    input  logic        i_cpu_wr,
    input  logic [13:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    output logic        o_cpu_ready,
    output logic        o_cpu_ovf,
    output logic        o_wr_err,
    input  logic        i_vram_loaded,
    output logic        o_vram_rden,
    output logic [13:0] o_vram_raddr,
    output logic        o_vram_wren,
    output logic [13:0] o_vram_waddr,
    output logic [15:0] o_vram_wdata,
    input  logic        i_vram_wrack,
    input  logic [15:0] i_vram_out,
    output logic [1:0]  o_dbg_state
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int CNTW = 8;

    localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(READ_HOLD - 1);
    localparam logic [CNTW-1:0] BURST_MAX = CNTW'(MAX_BURST);
    localparam logic [CNTW-1:0] TMO_LAST  = CNTW'(WR_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Write queue storage and bookkeeping
    logic [13:0]     r_fifo_addr [FIFO_DEPTH];
    logic [15:0]     r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            r_cpu_ready;
    logic            r_cpu_ovf;

    // Datapath registers
    logic            r_disp_ack;
    logic [15:0]     r_disp_data;
    logic [13:0]     r_raddr;
    logic [13:0]     r_waddr;
    logic [15:0]     r_wdata;
    logic            r_wr_err;
    logic [CNTW-1:0] r_hold;
    logic [CNTW-1:0] r_burst;
    logic [CNTW-1:0] r_tmo;

    // FSM decode strobes
    logic w_push;
    logic w_pop;
    logic w_fifo_ne;
    logic w_burst_cap;
    logic w_start_read;
    logic w_start_write;
    logic w_read_done;
    logic w_timeout;
    logic w_na_ack;

    assign w_push      = i_cpu_wr && r_cpu_ready;
    assign w_fifo_ne   = (r_count != '0);
    assign w_burst_cap = w_fifo_ne && (r_burst == BURST_MAX);

    // Next occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Queue pointers, occupancy, registered ready and sticky overflow
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cpu_ready <= 1'b1;
            r_cpu_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_next;
            r_cpu_ready <= (w_count_next < DEPTH_C);
            if (i_cpu_wr && !r_cpu_ready) r_cpu_ovf <= 1'b1;
        end
    end

    // Queue storage: contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= i_cpu_addr;
            r_fifo_data[r_wr_ptr] <= i_cpu_wdata;
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state and strobe decode. The ack cycle is a dead cycle so that a
    // request still held for the acked transfer is not granted twice.
    always_comb begin
        w_next_state  = r_state;
        w_start_read  = 1'b0;
        w_start_write = 1'b0;
        w_read_done   = 1'b0;
        w_pop         = 1'b0;
        w_timeout     = 1'b0;
        w_na_ack      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_disp_ack) begin
                    if (!i_vram_loaded) begin
                        w_na_ack = i_disp_req;
                    end else if (i_disp_req && !w_burst_cap) begin
                        w_next_state = ST_READ;
                        w_start_read = 1'b1;
                    end else if (w_fifo_ne) begin
                        w_next_state  = ST_WRITE;
                        w_start_write = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (r_hold == HOLD_LAST) begin
                    w_read_done  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_vram_wrack) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_tmo == TMO_LAST) begin
                    w_pop        = 1'b1;
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Read/write datapath, counters and sticky write error
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_disp_ack  <= 1'b0;
            r_disp_data <= '0;
            r_raddr     <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_wr_err    <= 1'b0;
            r_hold      <= '0;
            r_burst     <= '0;
            r_tmo       <= '0;
        end else begin
            r_disp_ack <= w_read_done || w_na_ack;
            if (w_read_done)   r_disp_data <= i_vram_out;
            else if (w_na_ack) r_disp_data <= '0;

            if (w_start_read) begin
                r_raddr <= i_disp_addr;
                r_hold  <= '0;
                if (w_fifo_ne) r_burst <= (r_burst == BURST_MAX) ? r_burst : r_burst + 1'b1;
                else           r_burst <= '0;
            end else if (w_start_write) begin
                r_waddr <= r_fifo_addr[r_rd_ptr];
                r_wdata <= r_fifo_data[r_rd_ptr];
                r_burst <= '0;
            end else if (r_state == ST_READ) begin
                r_hold <= r_hold + 1'b1;
            end

            if (r_state == ST_WRITE)     r_tmo <= '0;
            else if (r_state == ST_WAIT) r_tmo <= r_tmo + 1'b1;

            if (w_timeout) r_wr_err <= 1'b1;
        end
    end

    assign o_disp_ack   = r_disp_ack;
    assign o_disp_data  = r_disp_data;
    assign o_cpu_ready  = r_cpu_ready;
    assign o_cpu_ovf    = r_cpu_ovf;
    assign o_wr_err     = r_wr_err;
    assign o_vram_rden  = (r_state == ST_READ);
    assign o_vram_raddr = r_raddr;
    assign o_vram_wren  = (r_state == ST_WRITE);
    assign o_vram_waddr = r_waddr;
    assign o_vram_wdata = r_wdata;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter. Inputs change and outputs are checked
// 1 ns after each falling edge; a VRAM responder answers each write pulse
// with a wrack two cycles later when enabled.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        disp_req;
    logic [13:0] disp_addr;
    logic        disp_ack;
    logic [15:0] disp_data;
    logic        cpu_wr;
    logic [13:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_ovf;
    logic        wr_err;
    logic        vram_loaded;
    logic        vram_rden;
    logic [13:0] vram_raddr;
    logic        vram_wren;
    logic [13:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic        vram_wrack;
    logic [15:0] vram_out;
    logic [1:0]  dbg_state;

    vram_arbiter dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_disp_req    (disp_req),
        .i_disp_addr   (disp_addr),
        .o_disp_ack    (disp_ack),
        .o_disp_data   (disp_data),
        .i_cpu_wr      (cpu_wr),
        .i_cpu_addr    (cpu_addr),
        .i_cpu_wdata   (cpu_wdata),
        .o_cpu_ready   (cpu_ready),
        .o_cpu_ovf     (cpu_ovf),
        .o_wr_err      (wr_err),
        .i_vram_loaded (vram_loaded),
        .o_vram_rden   (vram_rden),
        .o_vram_raddr  (vram_raddr),
        .o_vram_wren   (vram_wren),
        .o_vram_waddr  (vram_waddr),
        .o_vram_wdata  (vram_wdata),
        .i_vram_wrack  (vram_wrack),
        .i_vram_out    (vram_out),
        .o_dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: expected writes in order, observed writes from the monitor
    logic [29:0] exp_q[$];
    logic [29:0] wr_log[$];

    int   rd_starts   = 0;
    int   wr_pulses   = 0;
    int   wr_at_reads = 0;
    int   both_cnt    = 0;
    logic prev_rden   = 1'b0;
    logic ack_en      = 1'b0;
    int   ack_cd      = 0;

    // Monitor and VRAM write responder
    always @(negedge clk) begin
        vram_wrack = 1'b0;
        if (ack_cd == 1) vram_wrack = 1'b1;
        if (ack_cd != 0) ack_cd = ack_cd - 1;
        if (vram_wren && ack_en) ack_cd = 2;
        if (vram_rden && !prev_rden) rd_starts = rd_starts + 1;
        prev_rden = vram_rden;
        if (vram_wren) begin
            wr_pulses   = wr_pulses + 1;
            wr_at_reads = rd_starts;
            wr_log.push_back({vram_waddr, vram_wdata});
        end
        if (vram_rden && vram_wren) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [13:0] a, input logic [15:0] d, input bit expect_write);
        cpu_wr    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        if (expect_write) exp_q.push_back({a, d});
        tick(1);
        cpu_wr = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_nwr"}, 96'(wr_log.size()), 96'(exp_q.size()));
        while (exp_q.size() > 0 && wr_log.size() > 0)
            check(tag, 96'(wr_log.pop_front()), 96'(exp_q.pop_front()));
        exp_q.delete();
        wr_log.delete();
    endtask

    int base;
    int wp_snap;

    initial begin
        reset       = 1'b1;
        disp_req    = 1'b0;
        disp_addr   = '0;
        cpu_wr      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        vram_loaded = 1'b0;
        vram_out    = '0;
        vram_wrack  = 1'b0;
        tick(2);

        // Reset values
        check("rst_ready", 96'(cpu_ready), 96'd1);
        check("rst_outs", 96'({disp_ack, disp_data, vram_rden, vram_raddr, vram_wren,
                              vram_waddr, vram_wdata, cpu_ovf, wr_err}), 96'd0);
        check("rst_state", 96'(dbg_state), 96'd0);
        reset = 1'b0;
        tick(1);

        // 1: preload, display answered with zero the cycle after the request
        disp_req  = 1'b1;
        disp_addr = 14'h0010;
        vram_out  = 16'hFFFF;
        tick(1);
        check("nl_ack", 96'({disp_ack, disp_data}), 96'({1'b1, 16'h0000}));
        disp_req = 1'b0;
        tick(1);
        check("nl_ack_pulse", 96'(disp_ack), 96'd0);
        check("nl_no_rden", 96'(rd_starts), 96'd0);

        // 2: single read held READ_HOLD cycles
        vram_loaded = 1'b1;
        vram_out    = 16'hBEEF;
        disp_req    = 1'b1;
        disp_addr   = 14'h1234;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("rd_hold%0d", i), 96'({vram_rden, vram_raddr, disp_ack}),
                  96'({1'b1, 14'h1234, 1'b0}));
        end
        tick(1);
        check("rd_ack", 96'({vram_rden, disp_ack, disp_data}), 96'({1'b0, 1'b1, 16'hBEEF}));
        disp_req = 1'b0;
        vram_out = 16'h0000;
        tick(1);
        check("rd_data_hold", 96'({disp_ack, disp_data}), 96'({1'b0, 16'hBEEF}));

        // 3: fill the queue during preload, overflow, then drain with wrack
        vram_loaded = 1'b0;
        tick(1);
        for (int i = 1; i <= 4; i++)
            push_wr(14'(i), 16'hAAA0 + 16'(i), 1'b1);
        check("full_ready", 96'(cpu_ready), 96'd0);
        check("full_no_ovf", 96'(cpu_ovf), 96'd0);
        push_wr(14'h0005, 16'hAAA5, 1'b0);
        check("ovf_set", 96'({cpu_ovf, cpu_ready}), 96'({1'b1, 1'b0}));
        check("nl_no_wren", 96'(wr_pulses), 96'd0);
        ack_en      = 1'b1;
        vram_loaded = 1'b1;
        tick(24);
        check("drain_pulses", 96'(wr_pulses), 96'd4);
        check("drain_flags", 96'({cpu_ready, cpu_ovf, wr_err, dbg_state}),
              96'({1'b1, 1'b1, 1'b0, 2'd0}));
        drain_check("drain_order");

        // 4: continuous display requests with one queued write
        vram_loaded = 1'b0;
        tick(1);
        push_wr(14'h0ABC, 16'h5A5A, 1'b1);
        base        = rd_starts;
        wp_snap     = wr_pulses;
        vram_out    = 16'h1357;
        disp_addr   = 14'h0100;
        disp_req    = 1'b1;
        vram_loaded = 1'b1;
        tick(60);
        check("burst_writes", 96'(wr_pulses - wp_snap), 96'd1);
        check("burst_reads_before", 96'(wr_at_reads - base), 96'd8);
        check("burst_resume", 96'((rd_starts - base) >= 10), 96'd1);
        disp_req = 1'b0;
        tick(6);
        check("burst_data", 96'({disp_data, dbg_state}), 96'({16'h1357, 2'd0}));
        drain_check("burst_wr");

        // 5: write timeout
        ack_en = 1'b0;
        push_wr(14'h0777, 16'hC0DE, 1'b1);
        tick(1);
        check("tmo_wren", 96'({vram_wren, vram_waddr, vram_wdata}), 96'({1'b1, 14'h0777, 16'hC0DE}));
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check($sformatf("tmo_wait%0d", i), 96'({vram_wren, wr_err, dbg_state}),
                  96'({1'b0, 1'b0, 2'd3}));
        end
        check("tmo_hold", 96'({vram_waddr, vram_wdata}), 96'({14'h0777, 16'hC0DE}));
        tick(1);
        check("tmo_err", 96'({wr_err, cpu_ready, dbg_state}), 96'({1'b1, 1'b1, 2'd0}));
        vram_out  = 16'h4444;
        disp_addr = 14'h0222;
        disp_req  = 1'b1;
        tick(1);
        check("tmo_next_rd", 96'({vram_rden, vram_raddr}), 96'({1'b1, 14'h0222}));
        tick(3);
        check("tmo_rd_ack", 96'({disp_ack, disp_data}), 96'({1'b1, 16'h4444}));
        disp_req = 1'b0;
        tick(2);
        drain_check("tmo_wr");

        // 6: reset while waiting for wrack with two entries queued
        vram_loaded = 1'b0;
        tick(1);
        push_wr(14'h0111, 16'h1111, 1'b1);
        push_wr(14'h0222, 16'h2222, 1'b0);
        vram_loaded = 1'b1;
        tick(2);
        check("rst6_in_wait", 96'(dbg_state), 96'd3);
        reset = 1'b1;
        #1;
        check("rst6_ready", 96'({cpu_ready, dbg_state}), 96'({1'b1, 2'd0}));
        check("rst6_outs", 96'({disp_ack, disp_data, vram_rden, vram_raddr, vram_wren,
                               vram_waddr, vram_wdata, cpu_ovf, wr_err}), 96'd0);
        tick(1);
        reset   = 1'b0;
        wp_snap = wr_pulses;
        tick(20);
        check("rst6_no_wren", 96'(wr_pulses - wp_snap), 96'd0);
        check("rst6_idle", 96'({cpu_ready, dbg_state}), 96'({1'b1, 2'd0}));
        drain_check("rst6_wr");

        check("no_overlap", 96'(both_cnt), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
